// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one shared single-digit adder, two cycles per digit
// (operand digits, then carry-in), ripple carry from digit 0 upward.

module bcd_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       S2,
  output logic [3:0] S1
);
  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, A} + {1'b0, B};
    S2  = 1'b0;
    S1  = raw[3:0];
    if (raw > 5'd9) begin
      S2 = 1'b1;
      // raw - 10 modulo 16 is raw + 6
      S1 = raw[3:0] + 4'd6;
    end
  end
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a_bcd,
  input  logic [4*DIGITS-1:0] b_bcd,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum_bcd,
  output logic                carry_out,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD_AB, ADD_CIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, shadow, shadow_merged;
  logic [IW-1:0]   idx;
  logic            c, c1;
  logic [3:0]      t;
  logic [3:0]      add_a, add_b, add_s1;
  logic            add_s2;
  logic            ops_ok, last_digit;

  function automatic logic all_digits_valid(input logic [W-1:0] x);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (x[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  bcd_adder u_add (
    .A  (add_a),
    .B  (add_b),
    .S2 (add_s2),
    .S1 (add_s1)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    add_a         = 4'd0;
    add_b         = 4'd0;
    ops_ok        = all_digits_valid(a_bcd) && all_digits_valid(b_bcd);
    last_digit    = (idx == IW'(DIGITS - 1));
    shadow_merged = shadow;
    shadow_merged[idx*4 +: 4] = add_s1;
    case (state)
      IDLE: begin
        if (start) state_nxt = ops_ok ? ADD_AB : DONE;
      end
      ADD_AB: begin
        busy      = 1'b1;
        add_a     = a_q[idx*4 +: 4];
        add_b     = b_q[idx*4 +: 4];
        state_nxt = ADD_CIN;
      end
      ADD_CIN: begin
        busy      = 1'b1;
        add_a     = t;
        add_b     = {3'b000, c};
        state_nxt = last_digit ? DONE : ADD_AB;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      shadow    <= '0;
      sum_bcd   <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      idx       <= '0;
      c         <= 1'b0;
      c1        <= 1'b0;
      t         <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a_bcd;
            b_q    <= b_bcd;
            shadow <= '0;
            idx    <= '0;
            c      <= 1'b0;
            err    <= !ops_ok;
            if (!ops_ok) begin
              sum_bcd   <= '0;
              carry_out <= 1'b0;
            end
          end
        end
        ADD_AB: begin
          t  <= add_s1;
          c1 <= add_s2;
        end
        ADD_CIN: begin
          // t + carry is at most 10, so c1 and add_s2 are never both set
          shadow <= shadow_merged;
          c      <= c1 | add_s2;
          if (last_digit) begin
            sum_bcd   <= shadow_merged;
            carry_out <= c1 | add_s2;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (DIGITS=4): driver queues expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_bcd_serial_add_ctrl;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a_bcd, b_bcd;
  logic         busy, done, carry_out, err;
  logic [W-1:0] sum_bcd;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .busy      (busy),
    .done      (done),
    .sum_bcd   (sum_bcd),
    .carry_out (carry_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         busy_seen = 1'b0;
  logic         chk_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
      if (rst) begin
        last_sum  = '0;
        last_cout = 1'b0;
        chk_low   = 1'b0;
      end else if (chk_low) begin
        check("done_one_cycle", {31'd0, done}, 32'd0);
        chk_low = 1'b0;
      end else if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum_bcd", {16'd0, sum_bcd}, {16'd0, e.sum});
          check("carry_out", {31'd0, carry_out}, {31'd0, e.cout});
          check("err", {31'd0, err}, {31'd0, e.err});
          check("latency", cyc - e.acc, e.lat);
          last_sum  = e.sum;
          last_cout = e.cout;
          chk_low   = 1'b1;
        end
      end
      if (!rst && busy === 1'b1)
        check("result_hold", {15'd0, carry_out, sum_bcd}, {15'd0, last_cout, last_sum});
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && done === 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] esum, input logic ecout, input logic eerr);
    exp_t e;
    wait_idle();
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    e.sum = esum; e.cout = ecout; e.err = eerr; e.acc = cyc + 1; e.lat = eerr ? 0 : 2 * D;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; a_bcd = '0; b_bcd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: all outputs and adder inputs at zero
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("reset_outputs", {12'd0, busy, done, err, carry_out, sum_bcd}, 32'd0);
      check("reset_adder_in", {24'd0, dut.add_a, dut.add_b}, 32'd0);
    end

    run_job(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
    run_job(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_job(16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0);

    // Invalid digit: immediate done with err, busy never rises
    wait_idle();
    busy_seen = 1'b0;
    run_job(16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_idle();
    check("err_no_busy", {31'd0, busy_seen}, 32'd0);
    check("err_held", {31'd0, err}, 32'd1);
    run_job(16'h0019, 16'h0081, 16'h0100, 1'b0, 1'b0);

    // start held 20 cycles with changing operands: only edges k and k+10 accept
    wait_idle();
    start = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) begin
        a_bcd = 16'h0500; b_bcd = 16'h0600;
        e.sum = 16'h1100; e.cout = 1'b0; e.err = 1'b0; e.acc = cyc + 1; e.lat = 2 * D;
        q.push_back(e);
      end else if (j == 10) begin
        a_bcd = 16'h8765; b_bcd = 16'h4321;
        e.sum = 16'h3086; e.cout = 1'b1; e.err = 1'b0; e.acc = cyc + 1; e.lat = 2 * D;
        q.push_back(e);
      end else begin
        a_bcd = 16'h1111 * (j % 4); b_bcd = 16'h2222;
      end
    end
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation: aborts with no done pulse
    wait_idle();
    a_bcd = 16'h4999; b_bcd = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {12'd0, busy, done, err, carry_out, sum_bcd}, 32'd0);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_job(16'h0045, 16'h0055, 16'h0100, 1'b0, 1'b0);

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
